// File: rtl/pcu_pkg.sv
// Shared types for the PC unit: FSM states, next-PC source codes, commit control bundle.
package pcu_pkg;

  localparam logic [31:0] PCU_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HALT
  } pcu_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JAL,
    SRC_JALR,
    SRC_TRAP,
    SRC_MRET
  } pcu_src_e;

  typedef struct packed {
    logic br_en;
    logic br_taken;
    logic jal_en;
    logic jalr_en;
    logic trap_en;
    logic mret_en;
  } pcu_ctrl_t;

endpackage

// File: rtl/pcu_target_sel.sv
// Combinational next-PC selection: priority mux over trap/mret/jalr/jal-branch/sequential.
module pcu_target_sel
  import pcu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ILEN_BYTES = 4
) (
  input  logic [XLEN-1:0] pc,
  input  pcu_ctrl_t       ctrl,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target,
  output pcu_src_e        src
);

  logic [XLEN-1:0] pc_seq, pc_rel, jalr_sum;

  // All sums wrap modulo 2^XLEN; wrap-around is a legal target.
  assign pc_seq   = pc + XLEN'(ILEN_BYTES);
  assign pc_rel   = pc + imm;
  assign jalr_sum = rs1_data + imm;

  always_comb begin
    target = pc_seq;
    src    = SRC_SEQ;
    if (ctrl.trap_en) begin
      target = mtvec;
      src    = SRC_TRAP;
    end else if (ctrl.mret_en) begin
      target = mepc;
      src    = SRC_MRET;
    end else if (ctrl.jalr_en) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
      src    = SRC_JALR;
    end else if (ctrl.jal_en) begin
      target = pc_rel;
      src    = SRC_JAL;
    end else if (ctrl.br_en && ctrl.br_taken) begin
      target = pc_rel;
      src    = SRC_BR;
    end
  end

endmodule

// File: rtl/pcu_fsm.sv
// Successor-PC unit: issues pc to IFU, waits for WBU commit, loads the selected target.
// Optional misaligned-target exception enabled by defining PCU_MISALIGN_EXC_EN.
module pcu_fsm
  import pcu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(PCU_RESET_PC),
  parameter int              ILEN_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  input  logic            cmt_valid,
  output logic            cmt_ready,
  input  logic            br_en,
  input  logic            br_taken,
  input  logic            jal_en,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            trap_en,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mepc,
  input  logic            halt_en,
  output logic            halted,
  output logic            exc_misalign,
  output logic [XLEN-1:0] exc_tval
);

  pcu_state_e      state_q, state_d;
  pcu_ctrl_t       ctrl;
  pcu_src_e        src;
  logic [XLEN-1:0] pc_q, target, pc_next;
  logic            commit;

  assign ctrl = '{br_en: br_en, br_taken: br_taken, jal_en: jal_en,
                  jalr_en: jalr_en, trap_en: trap_en, mret_en: mret_en};
  assign commit = cmt_valid && cmt_ready;
  assign pc     = pc_q;

  pcu_target_sel #(
    .XLEN       (XLEN),
    .ILEN_BYTES (ILEN_BYTES)
  ) u_target_sel (
    .pc       (pc_q),
    .ctrl     (ctrl),
    .imm      (imm),
    .rs1_data (rs1_data),
    .mtvec    (mtvec),
    .mepc     (mepc),
    .target   (target),
    .src      (src)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (pc_valid && pc_ready) state_d = S_WAIT;
      S_WAIT:  if (commit) state_d = halt_en ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Handshake outputs are masked during reset so nothing is offered mid-reset.
  always_comb begin
    pc_valid  = 1'b0;
    cmt_ready = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: pc_valid  = !rst;
      S_WAIT:  cmt_ready = !rst;
      S_HALT:  halted    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         pc_q <= RESET_PC;
    else if (commit) pc_q <= pc_next;
  end

`ifdef PCU_MISALIGN_EXC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

  logic            misalign, exc_q;
  logic [XLEN-1:0] tval_q;

  // Trap and mret targets come from CSRs and are trusted as-is.
  assign misalign = (src != SRC_TRAP) && (src != SRC_MRET) && ((target & ALIGN_MASK) != '0);
  assign pc_next  = misalign ? mtvec : target;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q  <= 1'b0;
      tval_q <= '0;
    end else begin
      exc_q <= commit && misalign;
      if (commit && misalign) tval_q <= target;
    end
  end

  assign exc_misalign = exc_q;
  assign exc_tval     = tval_q;
`else
  logic unused_src;
  assign unused_src   = ^src;
  assign pc_next      = target;
  assign exc_misalign = 1'b0;
  assign exc_tval     = '0;
`endif

endmodule

// File: tb/tb_pcu_fsm.sv
// Directed, table-driven bench for pcu_fsm; inputs driven and outputs sampled on the falling edge.
module tb_pcu_fsm;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, pc_valid, pc_ready, cmt_valid, cmt_ready;
  logic        br_en, br_taken, jal_en, jalr_en, trap_en, mret_en, halt_en;
  logic        halted, exc_misalign;
  logic [31:0] pc, imm, rs1_data, mtvec, mepc, exc_tval;

  int checks = 0;
  int errors = 0;
  logic [31:0] tval_m = '0;

  always #5 clk = ~clk;

  pcu_fsm dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .br_en(br_en), .br_taken(br_taken),
    .jal_en(jal_en), .jalr_en(jalr_en), .imm(imm), .rs1_data(rs1_data),
    .trap_en(trap_en), .mtvec(mtvec), .mret_en(mret_en), .mepc(mepc),
    .halt_en(halt_en), .halted(halted), .exc_misalign(exc_misalign), .exc_tval(exc_tval)
  );

  typedef struct {
    string       name;
    logic [31:0] pre;
    logic        br, tk, jal, jalr, trap, mret;
    logic [31:0] imm_v, rs1_v, mtvec_v, mepc_v, exp_pc;
    logic        mis;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    cmt_valid = 0; br_en = 0; br_taken = 0; jal_en = 0; jalr_en = 0;
    trap_en = 0; mret_en = 0; halt_en = 0; imm = '0; rs1_data = '0; mtvec = '0; mepc = '0;
  endtask

  // Hand the current pc to the core, then expect the wait state (the one bubble).
  task automatic do_fetch(input string nm);
    int n = 0;
    while (!pc_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_fetch_valid"}, {31'd0, pc_valid}, 32'd1);
    pc_ready = 1;
    @(negedge clk);
    pc_ready = 0;
    chk({nm, "_bubble_valid"}, {31'd0, pc_valid}, 32'd0);
    chk({nm, "_wait_ready"}, {31'd0, cmt_ready}, 32'd1);
  endtask

  task automatic do_commit(input string nm, input logic br, tk, jal, jalr, trap, mret, halt,
                           input logic [31:0] imm_v, rs1_v, mtvec_v, mepc_v, exp_pc,
                           input logic mis);
    logic [31:0] e_pc;
    logic        e_exc;
`ifdef PCU_MISALIGN_EXC_EN
    e_pc  = mis ? mtvec_v : exp_pc;
    e_exc = mis;
    if (mis) tval_m = exp_pc;
`else
    e_pc  = exp_pc;
    e_exc = 1'b0;
`endif
    br_en = br; br_taken = tk; jal_en = jal; jalr_en = jalr; trap_en = trap;
    mret_en = mret; halt_en = halt; imm = imm_v; rs1_data = rs1_v; mtvec = mtvec_v;
    mepc = mepc_v; cmt_valid = 1;
    @(negedge clk);
    clear_ctrl();
    chk({nm, "_pc"}, pc, e_pc);
    chk({nm, "_exc"}, {31'd0, exc_misalign}, {31'd0, e_exc});
    chk({nm, "_tval"}, exc_tval, tval_m);
    if (halt) chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
    else      chk({nm, "_refetch"}, {31'd0, pc_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    //           name           pre           br tk jl jr tp mr imm           rs1           mtvec         mepc          exp           mis
    vecs[0]  = '{"br_taken",    32'h80000010, 1, 1, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h80001000, 32'h0,        32'h80000000, 0};
    vecs[1]  = '{"br_not_taken",32'h80000010, 1, 0, 0, 0, 0, 0, 32'hFFFFFFF0, 32'h0,        32'h80001000, 32'h0,        32'h80000014, 0};
    vecs[2]  = '{"jal",         32'h80000010, 0, 0, 1, 0, 0, 0, 32'h00000100, 32'h0,        32'h80001000, 32'h0,        32'h80000110, 0};
    vecs[3]  = '{"jalr_mis",    32'h80000010, 0, 0, 0, 1, 0, 0, 32'h00000002, 32'h80000101, 32'h80001000, 32'h0,        32'h80000102, 1};
    vecs[4]  = '{"jalr_bit0",   32'h80000010, 0, 0, 0, 1, 0, 0, 32'h00000000, 32'h80000201, 32'h80001000, 32'h0,        32'h80000200, 0};
    vecs[5]  = '{"prio_trap",   32'h80000010, 0, 0, 1, 0, 1, 1, 32'h00000040, 32'h0,        32'h80001000, 32'h80000020, 32'h80001000, 0};
    vecs[6]  = '{"prio_mret",   32'h80000010, 0, 0, 1, 1, 0, 1, 32'h00000040, 32'h80000400, 32'h80001000, 32'h80000020, 32'h80000020, 0};
    vecs[7]  = '{"prio_jalr",   32'h80000010, 0, 0, 1, 1, 0, 0, 32'h00000008, 32'h80000400, 32'h80001000, 32'h0,        32'h80000408, 0};
    vecs[8]  = '{"jal_over_nt", 32'h80000010, 1, 0, 1, 0, 0, 0, 32'h00000040, 32'h0,        32'h80001000, 32'h0,        32'h80000050, 0};
    vecs[9]  = '{"seq_wrap",    32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h80001000, 32'h0,        32'h00000000, 0};
    vecs[10] = '{"jal_wrap",    32'h00000004, 0, 0, 1, 0, 0, 0, 32'hFFFFFFF8, 32'h0,        32'h80001000, 32'h0,        32'hFFFFFFFC, 0};
    vecs[11] = '{"trap_unchk",  32'h80000010, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h80001002, 32'h0,        32'h80001002, 0};
    vecs[12] = '{"br_mis",      32'h80000010, 1, 1, 0, 0, 0, 0, 32'h00000002, 32'h0,        32'h80001000, 32'h0,        32'h80000012, 1};

    rst = 1; pc_ready = 0;
    clear_ctrl();

    // Reset and first sequential instruction.
    @(negedge clk);
    chk("rst_valid_low", {31'd0, pc_valid}, 32'd0);
    chk("rst_ready_low", {31'd0, cmt_ready}, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_valid_first", {31'd0, pc_valid}, 32'd1);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
    chk("rst_tval", exc_tval, 32'd0);
    do_fetch("seq0");
    do_commit("seq0", 0,0,0,0,0,0,0, 0, 0, 0, 0, 32'h80000004, 0);

    // Backpressure: pc and pc_valid hold while IFU stalls.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, pc_valid}, 32'd1);
      chk("bp_pc", pc, 32'h80000004);
    end
    do_fetch("bp");
    do_commit("bp", 0,0,0,0,0,0,0, 0, 0, 0, 0, 32'h80000008, 0);

    // Table: move pc to the record's start via an aligned jalr, then apply the record.
    for (int v = 0; v < 13; v++) begin
      do_fetch({vecs[v].name, "_pre"});
      do_commit({vecs[v].name, "_pre"}, 0,0,0,1,0,0,0, 32'h0, vecs[v].pre, 32'h0, 32'h0, vecs[v].pre, 0);
      do_fetch(vecs[v].name);
      do_commit(vecs[v].name, vecs[v].br, vecs[v].tk, vecs[v].jal, vecs[v].jalr,
                vecs[v].trap, vecs[v].mret, 1'b0, vecs[v].imm_v, vecs[v].rs1_v,
                vecs[v].mtvec_v, vecs[v].mepc_v, vecs[v].exp_pc, vecs[v].mis);
    end

    // Pulse must already be gone one cycle later.
    @(negedge clk);
    chk("exc_pulse_end", {31'd0, exc_misalign}, 32'd0);

    // Halt with a trap: target still taken, fetch stops until reset.
    do_fetch("halt");
    do_commit("halt", 0,0,1,0,1,0,1, 32'h40, 0, 32'h80003000, 0, 32'h80003000, 0);
    pc_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_no_fetch", {31'd0, pc_valid}, 32'd0);
      chk("halt_hold", {31'd0, halted}, 32'd1);
    end
    pc_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("halt_rst_pc", pc, RST_PC);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    chk("halt_rst_valid", {31'd0, pc_valid}, 32'd1);

    // Reset beats a commit presented in the same cycle.
    do_fetch("midrst");
    jal_en = 1; imm = 32'h100; cmt_valid = 1; rst = 1;
    #1;
    chk("midrst_ready_masked", {31'd0, cmt_ready}, 32'd0);
    @(negedge clk);
    clear_ctrl();
    rst = 0;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_fetch", {31'd0, pc_valid}, 32'd1);
    chk("midrst_not_wait", {31'd0, cmt_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
